// File: rtl/pc8001m_pkg.sv
// Shared types for the PC-8001 ROM loader: loader FSM states and default download index.
package pc8001m_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DRAIN,
      HOLD,
      RUN
   } rom_ld_state_t;

   localparam logic [7:0] ROM_LD_IDX_DEFAULT = 8'd0;

endpackage

// File: rtl/pc8001m_rst_stretch.sv
// Loadable down-counter that sets how long the core stays in reset after a load.
// done_o flags the last HOLD cycle. The count stops at 1 and never wraps.
module pc8001m_rst_stretch #(
   parameter int unsigned RST_HOLD = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic dec_i,
   output logic done_o
);

   localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = HOLD_INIT;
      else if (dec_i && cnt_q > 8'd1)
         cnt_d = cnt_q - 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= HOLD_INIT;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == 8'd1);

endmodule

// File: rtl/pc8001m_rom_loader.sv
// Sequences HPS ioctl downloads into the PC-8001 program memory and shares its port with CPU reads.
// Optional checksum accumulator: define PC8001M_ROM_SUM_EN to build it.
module pc8001m_rom_loader
   import pc8001m_pkg::*;
#(
   parameter int unsigned ADDR_W     = 15,
   parameter logic [7:0]  LOAD_INDEX = ROM_LD_IDX_DEFAULT,
   parameter int unsigned RST_HOLD   = 16
) (
   input  logic              clk_sys_i,
   input  logic              reset_i,
   input  logic              ioctl_download_i,
   input  logic [7:0]        ioctl_index_i,
   input  logic              ioctl_wr_i,
   input  logic [24:0]       ioctl_addr_i,
   input  logic [7:0]        ioctl_dout_i,
   output logic              ioctl_wait_o,
   input  logic              cpu_req_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   output logic [7:0]        cpu_rdata_o,
   output logic              cpu_ack_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   output logic              mem_we_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              core_reset_o,
   output logic              load_done_o,
   output logic              load_err_o,
   output logic [7:0]        load_sum_o
);

   rom_ld_state_t state_q, state_d;

   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;
   logic              rd_issued_q;
   logic              rd_pend_q;
   logic              cpu_ack_q;
   logic              load_err_q;
   logic              from_load_q;
   logic              hold_done;

   logic dl_match, load_entry, in_range, wr_acc, wr_drop;

   assign dl_match   = ioctl_download_i && (ioctl_index_i == LOAD_INDEX);
   assign load_entry = dl_match && (state_q inside {IDLE, RUN, HOLD});
   assign in_range   = (ioctl_addr_i >> ADDR_W) == 25'd0;
   assign wr_acc     = (state_q == LOAD) && ioctl_wr_i && in_range;
   assign wr_drop    = (state_q == LOAD) && ioctl_wr_i && !in_range;

   pc8001m_rst_stretch #(
      .RST_HOLD (RST_HOLD)
   ) u_rst_stretch (
      .clk_i  (clk_sys_i),
      .rst_i  (reset_i),
      .load_i (load_entry),
      .dec_i  (state_q == HOLD),
      .done_o (hold_done)
   );

   always_ff @(posedge clk_sys_i) begin
      if (reset_i)
         state_q <= HOLD;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = dl_match ? LOAD : RUN;
         RUN:     if (dl_match) state_d = LOAD;
         HOLD: begin
            if (dl_match)
               state_d = LOAD;
            else if (hold_done)
               state_d = IDLE;
         end
         LOAD:    if (!ioctl_download_i) state_d = DRAIN;
         DRAIN:   if (!mem_we_q) state_d = HOLD;
         default: state_d = HOLD;
      endcase
   end

   // The core leaves reset in IDLE; the done pulse fires only when IDLE follows a download.
   always_comb begin
      core_reset_o = 1'b1;
      load_done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            core_reset_o = 1'b0;
            load_done_o  = from_load_q;
         end
         RUN:     core_reset_o = 1'b0;
         default: ;
      endcase
   end

   // The registered memory port is the one-entry write buffer: a captured byte is
   // presented on the port in the very cycle it becomes valid and leaves it on the next.
   always_ff @(posedge clk_sys_i) begin
      if (reset_i) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'd0;
         rd_issued_q <= 1'b0;
         rd_pend_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         load_err_q  <= 1'b0;
         from_load_q <= 1'b0;
      end else begin
         mem_we_q  <= 1'b0;
         rd_pend_q <= 1'b0;
         cpu_ack_q <= rd_pend_q;
         if (wr_acc) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ioctl_addr_i[ADDR_W-1:0];
            mem_wdata_q <= ioctl_dout_i;
         end else if (cpu_req_i && !rd_issued_q) begin
            mem_addr_q  <= cpu_addr_i;
            rd_pend_q   <= 1'b1;
            rd_issued_q <= 1'b1;
         end
         if (cpu_ack_q)
            rd_issued_q <= 1'b0;

         if (load_entry)
            load_err_q <= 1'b0;
         else if (wr_drop)
            load_err_q <= 1'b1;

         if (load_entry)
            from_load_q <= 1'b1;
         else if (state_q == IDLE)
            from_load_q <= 1'b0;
      end
   end

`ifdef PC8001M_ROM_SUM_EN
   logic [7:0] sum_q;

   always_ff @(posedge clk_sys_i) begin
      if (reset_i || load_entry)
         sum_q <= 8'd0;
      else if (wr_acc)
         sum_q <= sum_q + ioctl_dout_i;
   end

   assign load_sum_o = sum_q;
`else
   assign load_sum_o = 8'd0;
`endif

   assign ioctl_wait_o = mem_we_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign cpu_ack_o    = cpu_ack_q;
   assign cpu_rdata_o  = cpu_ack_q ? mem_rdata_i : 8'd0;
   assign load_err_o   = load_err_q;

endmodule

// File: doc/pc8001m_rom_loader.md
# pc8001m_rom_loader

Sequences HPS ROM downloads into the PC-8001 core's single-port program memory and arbitrates that port between the download stream and CPU reads. The block sits in the `emu` top between `hps_io`'s ioctl outputs and the `pc8001m` core's ROM interface. It holds the core in reset for the whole load and releases it cleanly afterwards. It also reports load completion, out-of-range bytes and, optionally, a checksum.

## Interface
Parameters:
- `ADDR_W`, default 15: memory address width (32 KiB).
- `LOAD_INDEX`, default 8'd0: `ioctl_index` value that targets this memory.
- `RST_HOLD`, default 16: number of `clk_sys` cycles `core_reset` stays high after the last write drains. Legal range is 1–255.

Ports (one clock; reset is synchronous and active-high):
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ioctl_download`  in  1  download active (from `hps_io`).
- `ioctl_index`  in  8  download target index.
- `ioctl_wr`  in  1  one-cycle strobe: byte valid.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_wait`  out  1  stall request to `hps_io`.
- `cpu_req`  in  1  read request. Level signal, held until `cpu_ack`.
- `cpu_addr`  in  ADDR_W  read address.
- `cpu_rdata`  out  8  read data. Valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle read acknowledge.
- `mem_addr`  out  ADDR_W  memory address (registered).
- `mem_wdata`  out  8  memory write data (registered).
- `mem_we`  out  1  memory write enable (registered).
- `mem_rdata`  in  8  memory read data, valid 1 cycle after `mem_addr`.
- `core_reset`  out  1  reset to `pc8001m`.
- `load_done`  out  1  one-cycle pulse when the core leaves reset after a download.
- `load_err`  out  1  sticky flag: at least one byte was dropped as out of range.
- `load_sum`  out  8  additive checksum (see Configuration).

## Operation
State machine, states `IDLE`, `LOAD`, `DRAIN`, `HOLD`, `RUN`:
- Reset enters `HOLD` with hold counter = `RST_HOLD`. This gives power-on the same release path as a download.
- Reset values:
  - `core_reset`=1.
  - `ioctl_wait`, `cpu_ack`, `mem_we`, `load_done`, `load_err`=0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `load_sum`=0.
  - Write buffer is empty.
- `IDLE`: transitional, one cycle, then go to `RUN`. Only reachable through `HOLD`.
- `RUN`, `IDLE`, `HOLD` → `LOAD` when `ioctl_download`=1 and `ioctl_index`==`LOAD_INDEX`. On this entry:
  - `core_reset`=1.
  - `load_err` and `load_sum` are cleared.
  - The hold counter is reloaded.
- `LOAD`:
  - Each `ioctl_wr` with `ioctl_addr` < 2**ADDR_W is captured into a 1-entry buffer (address, data).
  - A byte with `ioctl_addr` ≥ 2**ADDR_W is dropped and sets `load_err`.
  - A download whose index does not match is ignored entirely: no stall, no reset.
- `LOAD` → `DRAIN` when `ioctl_download` falls.
- `DRAIN` → `HOLD` when the buffer is empty.
- `HOLD`: decrement the counter each cycle. When it reaches 1, go to `RUN`: `core_reset`=0 and `load_done`=1 for one cycle. `load_done` does not pulse on power-on release.

Memory port arbitration, decided each cycle:
- A pending buffered write always wins.
- Otherwise a `cpu_req` that is not yet issued gets the port.
- CPU reads are served in every state, so a read in flight when a load starts still completes.
- A read never aborts.
- `ioctl_wait` = buffer valid. This throttles `hps_io` to one byte per 2 cycles worst case.

## Timing
- Write: `ioctl_wr` in cycle N → buffer valid in N+1 → `mem_we`=1 with address/data in N+1. Buffer is empty in N+2.
- Read, granted: `cpu_req` first seen in cycle N → `mem_addr` driven in N+1 → `cpu_ack`=1 and `cpu_rdata`=`mem_rdata` in N+2.
- Read delayed by a write: each write in N+1 pushes the read grant back by one cycle.
- `cpu_req` must be held high until `cpu_ack`. It may be asserted again in the cycle after `cpu_ack`.
- Both the download-start condition and `reset` in the same cycle: `reset` wins.
- `reset` during `LOAD`: the buffer is discarded and the block enters `HOLD`.
- Address wrap is not possible: out-of-range bytes are dropped, not truncated.

## Configuration
- `PC8001M_ROM_SUM_EN` defined: `load_sum` accumulates (mod 256) every accepted byte of the current download and holds its value after `LOAD` ends.
- Macro undefined: the accumulator is not built and `load_sum` is tied to 8'd0.

## Structure
- Shared package `pc8001m_pkg`:
  - state enum `rom_ld_state_t`;
  - localparam `ROM_LD_IDX_DEFAULT` = 8'd0.
- One sub-module, `pc8001m_rst_stretch`: a loadable down-counter that produces the `HOLD` release strobe.

## Test plan
- Power-on: assert `reset` for 3 cycles → `core_reset` stays 1 until exactly `RST_HOLD` cycles after release. `load_done` stays 0.
- Load 4 bytes 0x11, 0x22, 0x33, 0x44 at addresses 0–3, index 0 → `mem_we` pulses four times with matching addr/data. `ioctl_wait` is high 1 cycle per byte. `load_done` pulses `RST_HOLD` cycles after the drain. `load_sum`=0xAA with the macro, 0x00 without it.
- Byte at `ioctl_addr`=0x8000 → no `mem_we`. `load_err`=1 until the next matching download starts.
- `ioctl_wr` and `cpu_req` (addr 0x0100) in the same cycle → write at N+1, read address at N+2, `cpu_ack` at N+3 with `mem_rdata` data.
- Download with `ioctl_index`=1 → `core_reset` stays 0, no writes, `ioctl_wait`=0.
- `reset` asserted mid-`LOAD` with the buffer full → no `mem_we` follows. The block enters `HOLD` and releases after `RST_HOLD` cycles.
